chord_voice_scheduler: RTL

Chord voice scheduler: allocates incoming notes to a fixed pool of voice slots, counts each slot's duration down on `beat`, and time-multiplexes one shared note-player engine across all active slots. It sits between the song reader (`note`/`duration`/`new_note`) and the codec sample path (`generate_next_sample` → `sample_out`/`new_sample_ready`). It replaces per-voice note-player instances with one shared engine.

---
 rtl/chord_pkg.sv | 18 +
 rtl/voice_slot.sv | 35 +++
 rtl/chord_voice_scheduler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/chord_pkg.sv
// Shared defaults, sample-sweep FSM states and note constants for the chord voice scheduler.
package chord_pkg;

  localparam int DEF_NUM_VOICES = 3;
  localparam int DEF_NOTE_W     = 6;
  localparam int DEF_DUR_W      = 6;
  localparam int DEF_SAMPLE_W   = 16;

  localparam logic [DEF_NOTE_W-1:0] REST_NOTE = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WAIT,
    ST_OUT
  } sched_state_t;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: note register plus beat-driven remaining-duration counter.
// Load takes effect next cycle and wins over a same-cycle beat; no backpressure.
module voice_slot import chord_pkg::*; #(
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int DUR_W  = DEF_DUR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play,
  input  logic              load,
  input  logic              beat,
  input  logic [NOTE_W-1:0] load_note,
  input  logic [DUR_W-1:0]  load_dur,
  output logic [NOTE_W-1:0] note,
  output logic              busy
);

  logic [DUR_W-1:0] remaining;

  // The note register is kept after the slot frees so an in-flight sweep can still read it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      note      <= '0;
      remaining <= '0;
    end else if (load) begin
      note      <= load_note;
      remaining <= load_dur;
    end else if (beat && play && (remaining != '0)) begin
      remaining <= remaining - DUR_W'(1);
    end
  end

  assign busy = (remaining != '0);

endmodule

// File: rtl/chord_voice_scheduler.sv
// Chord voice scheduler: allocates notes to voice slots and sweeps one shared engine over them.
// Latency: sample ready 1+NUM_VOICES+active*E cycles after request; allocation/beat visible next cycle.
// No backpressure: full pool drops the note (note_dropped); CHORD_SATURATE_EN selects saturating mix.
module chord_voice_scheduler import chord_pkg::*; #(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int DUR_W      = DEF_DUR_W,
  parameter int SAMPLE_W   = DEF_SAMPLE_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          play,
  input  logic [NOTE_W-1:0]             note,
  input  logic [DUR_W-1:0]              duration,
  input  logic                          new_note,
  input  logic                          beat,
  input  logic                          generate_next_sample,
  output logic signed [SAMPLE_W-1:0]    sample_out,
  output logic                          new_sample_ready,
  output logic                          v_start,
  output logic [$clog2(NUM_VOICES)-1:0] v_sel,
  output logic [NOTE_W-1:0]             v_note,
  input  logic signed [SAMPLE_W-1:0]    v_sample,
  input  logic                          v_sample_valid,
  output logic [NUM_VOICES-1:0]         slot_start,
  output logic [NUM_VOICES-1:0]         voice_busy,
  output logic                          note_dropped
);

  localparam int L     = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + L;
  localparam logic [L-1:0] LAST_IDX = L'(NUM_VOICES - 1);

  logic [NUM_VOICES-1:0] busy;
  logic [NUM_VOICES-1:0] alloc_oh;
  logic [NUM_VOICES-1:0] load_vec;
  logic                  found;
  logic                  accept;
  logic [NOTE_W-1:0]     slot_note [NUM_VOICES];

  assign accept = new_note && play && (note != NOTE_W'(REST_NOTE)) && (duration != '0);

  // Uses the pre-beat busy mask, so a slot freed by a same-cycle beat is not reused yet.
  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!found && !busy[i]) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign load_vec = accept ? alloc_oh : '0;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(
      .NOTE_W (NOTE_W),
      .DUR_W  (DUR_W)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .play      (play),
      .load      (load_vec[i]),
      .beat      (beat),
      .load_note (note),
      .load_dur  (duration),
      .note      (slot_note[i]),
      .busy      (busy[i])
    );
  end

  assign voice_busy = busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_start   <= '0;
      note_dropped <= 1'b0;
    end else begin
      slot_start   <= load_vec;
      note_dropped <= accept && !found;
    end
  end

  sched_state_t            state, state_nxt;
  logic [L-1:0]            idx, idx_nxt;
  logic [NUM_VOICES-1:0]   snap, snap_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [SAMPLE_W-1:0] mix;
  logic                    last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      snap       <= '0;
      acc        <= '0;
      sample_out <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      snap  <= snap_nxt;
      acc   <= acc_nxt;
      if (state_nxt == ST_OUT) sample_out <= mix;
    end
  end

  always_comb begin
    state_nxt        = state;
    idx_nxt          = idx;
    snap_nxt         = snap;
    acc_nxt          = acc;
    v_start          = 1'b0;
    v_sel            = '0;
    v_note           = '0;
    new_sample_ready = 1'b0;
    last             = (idx == LAST_IDX);
    case (state)
      ST_IDLE: begin
        if (generate_next_sample) begin
          // Paused sweeps see an empty snapshot: no engine traffic, zero output.
          snap_nxt  = play ? busy : '0;
          acc_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (snap[idx]) begin
          v_start   = 1'b1;
          v_sel     = idx;
          v_note    = slot_note[idx];
          state_nxt = ST_WAIT;
        end else begin
          idx_nxt   = idx + L'(1);
          state_nxt = last ? ST_OUT : ST_SCAN;
        end
      end
      ST_WAIT: begin
        if (v_sample_valid) begin
          acc_nxt   = acc + $signed({{L{v_sample[SAMPLE_W-1]}}, v_sample});
          idx_nxt   = idx + L'(1);
          state_nxt = last ? ST_OUT : ST_SCAN;
        end
      end
      ST_OUT: begin
        new_sample_ready = 1'b1;
        state_nxt        = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef CHORD_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  always_comb begin
    if (acc_nxt > SAT_HI)      mix = SAT_HI[SAMPLE_W-1:0];
    else if (acc_nxt < SAT_LO) mix = SAT_LO[SAMPLE_W-1:0];
    else                       mix = acc_nxt[SAMPLE_W-1:0];
  end
`else
  assign mix = SAMPLE_W'(acc_nxt >>> L);
`endif

endmodule
